wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback-stage arbiter between the in-order pipeline and the register file's single write port. It merges two result sources: the pipeline's MEM/WB result, and completions from the long-latency unit (mul/div, with results returned out of band). It drives the regfile write controls (load, dest, in, use_rd) from a registered output stage. Long-latency results wait in a small FIFO and drain into idle writeback slots. Older queued results are squashed by newer pipeline writes to the same register.

## Interface
Parameters:
- DEPTH, 2: long-latency result FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive cycles a live FIFO head may wait before the pipeline is stalled; ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_valid  in  1  pipeline WB slot holds an instruction.
- pipe_wen  in  1  that instruction writes rd.
- pipe_rd  in  5  destination register.
- pipe_data  in  32  result value.
- ll_valid  in  1  long-latency unit presents a result.
- ll_rd  in  5  its destination register.
- ll_data  in  32  its value.
- ll_ready  out  1  FIFO can accept; transfer when ll_valid && ll_ready.
- pipe_stall  out  1  registered; pipeline must present pipe_valid=0 in every cycle it is high.
- busy_mask  out  32  bit r set when a live FIFO entry targets r; bit 0 always 0.
- rf_load  out  1  registered regfile write enable.
- rf_use_rd  out  1  registered; equals rf_load.
- rf_dest  out  5  registered write register.
- rf_in  out  32  registered write data.

## Operation
- A pipeline write is pipe_valid && pipe_wen && pipe_rd != 0. It always has priority and is never delayed.
- FIFO entry = {live, rd, data}.
  - Push: when ll_valid && ll_ready. live=0 if ll_rd==0.
  - ll_ready = (count != DEPTH), combinational from the current count. A pop in the same cycle does not free a slot early.
- Squash: a pipeline write to register r clears live on every FIFO entry with rd==r. This includes an entry being pushed in the same cycle. The pipeline instruction is defined as younger.
- Drain, evaluated each cycle on the FIFO head:
  - Dead head: popped with no write. It does not use the write slot.
  - Live head with no pipeline write this cycle: popped and written.
  - Live head with a pipeline write this cycle: held.
- Push and pop in the same cycle are both performed; count is unchanged.
- Starvation:
  - starve_cnt increments each cycle a live head is held. It clears when the head pops or the FIFO is empty.
  - When starve_cnt reaches STARVE_LIMIT, pipe_stall is set next edge. It clears on the edge after the live head is written.
  - If pipe_valid is asserted while pipe_stall=1, the pipeline write still wins. No data is lost; the stall simply persists.
- Output stage:
  - Selected write (pipeline or FIFO head) → rf_load/rf_use_rd=1, rf_dest, rf_in on the next edge.
  - No write → rf_load=rf_use_rd=0. rf_dest and rf_in hold their previous values.
- busy_mask is combinational from the FIFO contents (live entries only). It reflects squashes and pushes after the edge on which they occur.

## Timing
- Reset (async assert, synchronous release): FIFO empty, pointers 0, starve_cnt=0. Outputs: pipe_stall=0, rf_load=0, rf_use_rd=0, rf_dest=0, rf_in=0, busy_mask=0, ll_ready=1.
- Reset mid-operation discards all queued results.
- Latency, pipeline input to regfile write: 1 cycle.
- Latency, FIFO push to regfile write: minimum 2 cycles (push edge, then drain cycle, then output edge).
- Throughput: at most one regfile write per cycle.
- Full FIFO: ll_ready=0 until a pop edge. ll_valid may stay high; the result is held by the source.
- Pointer wrap: modulo DEPTH. Count is log2(DEPTH)+1 bits.

## Test plan
- Pipeline only: pipe write x5=0xDEADBEEF with FIFO empty → next cycle rf_load=1, rf_dest=5, rf_in=0xDEADBEEF. pipe_rd=0 → rf_load=0.
- Idle drain: ll push x7=0x12 with no pipeline writes → busy_mask[7]=1 after the edge. rf_load=1, rf_dest=7, rf_in=0x12 two edges after the push. busy_mask=0 afterwards.
- Squash: queue x9=0xAA, then pipe write x9=0xBB → one regfile write only, rf_in=0xBB. The dead entry is discarded and busy_mask[9] clears.
- Full/backpressure (DEPTH=2): push x1 and x2 during continuous pipeline writes → ll_ready=0. A third ll_valid is held. After the pipeline idles, writes occur in order x1, x2, x3 and ll_ready returns to 1.
- Starvation (STARVE_LIMIT=4): queue x3, then pipe writes every cycle → pipe_stall=1 after 4 held cycles. The bench drops pipe_valid, x3 is written, and pipe_stall=0 on the following edge.
- Async reset with 2 entries queued and pipe_stall=1 → all outputs 0 immediately. No queued write appears after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline MEM/WB results and long-latency unit completions
// onto the single regfile write port. Pipeline writes always win; long-latency
// results wait in a small FIFO, drain into idle slots, and are squashed by
// younger pipeline writes to the same register. A head that waits too long
// raises pipe_stall so it can eventually drain.
module wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_valid,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        ll_valid,
  input  logic [4:0]  ll_rd,
  input  logic [31:0] ll_data,
  output logic        ll_ready,
  output logic        pipe_stall,
  output logic [31:0] busy_mask,
  output logic        rf_load,
  output logic        rf_use_rd,
  output logic [4:0]  rf_dest,
  output logic [31:0] rf_in
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
  localparam logic [SW-1:0] LIMIT_C = STARVE_LIMIT[SW-1:0];

  // FIFO storage; a slot's live bit is cleared when it pops, so unoccupied
  // slots never contribute to busy_mask.
  logic          fifo_live [DEPTH];
  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [SW-1:0] starve_cnt;

  logic          pipe_write;
  logic          fifo_nonempty;
  logic          head_live;
  logic          push;
  logic          push_live;
  logic          pop;
  logic          fifo_write;
  logic          held;
  logic [SW-1:0] starve_nxt;
  logic          stall_nxt;

  assign ll_ready  = (count != DEPTH_C);
  assign rf_use_rd = rf_load;

  // Per-cycle arbitration decisions from current FIFO state and inputs.
  always_comb begin
    pipe_write    = pipe_valid && pipe_wen && (pipe_rd != 5'd0);
    fifo_nonempty = (count != '0);
    head_live     = fifo_nonempty && fifo_live[rd_ptr];
    push          = ll_valid && ll_ready;
    // The incoming entry is older than the pipeline instruction, so a
    // same-cycle pipeline write to the same register kills it on entry.
    push_live     = (ll_rd != 5'd0) && !(pipe_write && (pipe_rd == ll_rd));
    fifo_write    = head_live && !pipe_write;
    held          = head_live && pipe_write;
    pop           = fifo_nonempty && (!fifo_live[rd_ptr] || !pipe_write);

    starve_nxt = '0;
    if (held) begin
      if (starve_cnt == LIMIT_C) starve_nxt = starve_cnt;
      else                       starve_nxt = starve_cnt + 1'b1;
    end
    // Stall holds until the head stops being held (written, squashed and
    // popped, or gone), so it cannot get stuck on a dead head.
    stall_nxt = held && (pipe_stall || (starve_nxt == LIMIT_C));
  end

  // FIFO entries, pointers and occupancy, including squash of matching entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_live[i] <= 1'b0;
        fifo_rd[i]   <= 5'd0;
        fifo_data[i] <= 32'd0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pop && (rd_ptr == AW'(i))) fifo_live[i] <= 1'b0;
        if (pipe_write && (fifo_rd[i] == pipe_rd)) fifo_live[i] <= 1'b0;
        if (push && (wr_ptr == AW'(i))) begin
          fifo_live[i] <= push_live;
          fifo_rd[i]   <= ll_rd;
          fifo_data[i] <= ll_data;
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Starvation counter and the stall request it drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      pipe_stall <= stall_nxt;
    end
  end

  // Registered regfile write port; dest/data hold when nothing is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_load <= 1'b0;
      rf_dest <= 5'd0;
      rf_in   <= 32'd0;
    end else begin
      rf_load <= pipe_write || fifo_write;
      if (pipe_write) begin
        rf_dest <= pipe_rd;
        rf_in   <= pipe_data;
      end else if (fifo_write) begin
        rf_dest <= fifo_rd[rd_ptr];
        rf_in   <= fifo_data[rd_ptr];
      end
    end
  end

  // Registers targeted by live queued results; x0 is never reported busy.
  always_comb begin
    busy_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_live[i]) busy_mask[fifo_rd[i]] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios then random traffic, all
// compared against a queue-based reference model of the writeback rules.
module tb_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_valid = 1'b0;
  logic        pipe_wen = 1'b0;
  logic [4:0]  pipe_rd = 5'd0;
  logic [31:0] pipe_data = 32'd0;
  logic        ll_valid = 1'b0;
  logic [4:0]  ll_rd = 5'd0;
  logic [31:0] ll_data = 32'd0;
  logic        ll_ready;
  logic        pipe_stall;
  logic [31:0] busy_mask;
  logic        rf_load;
  logic        rf_use_rd;
  logic [4:0]  rf_dest;
  logic [31:0] rf_in;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
    .pipe_stall(pipe_stall), .busy_mask(busy_mask),
    .rf_load(rf_load), .rf_use_rd(rf_use_rd), .rf_dest(rf_dest), .rf_in(rf_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  int          m_starve = 0;
  logic        m_stall = 1'b0;
  logic        m_load = 1'b0;
  logic [4:0]  m_dest = 5'd0;
  logic [31:0] m_in = 32'd0;
  logic        m_last_push = 1'b0;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_busy();
    logic [31:0] b = 32'd0;
    foreach (m_q[i]) if (m_q[i].live) b[m_q[i].rd] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  task automatic check_all(input string ctx);
    chk({ctx, ".rf_load"},   32'(rf_load),    32'(m_load));
    chk({ctx, ".rf_use_rd"}, 32'(rf_use_rd),  32'(m_load));
    chk({ctx, ".rf_dest"},   32'(rf_dest),    32'(m_dest));
    chk({ctx, ".rf_in"},     rf_in,           m_in);
    chk({ctx, ".pipe_stall"},32'(pipe_stall), 32'(m_stall));
    chk({ctx, ".busy_mask"}, busy_mask,       m_busy());
    chk({ctx, ".ll_ready"},  32'(ll_ready),   32'(m_q.size() < DEPTH));
  endtask

  // One clock: drive inputs, advance the reference model, compare after the edge.
  task automatic step(input string ctx, input logic pv, input logic pw_en, input logic [4:0] prd,
                      input logic [31:0] pd, input logic llv, input logic [4:0] lrd, input logic [31:0] ld);
    logic pw, push, held;
    ent_t e;
    pipe_valid = pv; pipe_wen = pw_en; pipe_rd = prd; pipe_data = pd;
    ll_valid = llv; ll_rd = lrd; ll_data = ld;
    pw   = pv && pw_en && (prd != 5'd0);
    push = llv && (m_q.size() < DEPTH);
    held = 1'b0;
    m_load = 1'b0;
    if (pw) begin
      m_load = 1'b1; m_dest = prd; m_in = pd;
    end
    if (m_q.size() > 0) begin
      if (!m_q[0].live) m_q.delete(0);
      else if (!pw) begin
        m_load = 1'b1; m_dest = m_q[0].rd; m_in = m_q[0].data;
        m_q.delete(0);
      end else held = 1'b1;
    end
    if (pw) foreach (m_q[i]) if (m_q[i].rd == prd) m_q[i].live = 1'b0;
    if (push) begin
      e.live = (lrd != 5'd0) && !(pw && (lrd == prd));
      e.rd = lrd; e.data = ld;
      m_q.push_back(e);
    end
    if (held) begin
      if (m_starve < LIMIT) m_starve++;
      m_stall = m_stall || (m_starve == LIMIT);
    end else begin
      m_starve = 0;
      m_stall = 1'b0;
    end
    m_last_push = push;
    @(posedge clk); #1;
    check_all(ctx);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_starve = 0; m_stall = 1'b0; m_load = 1'b0; m_dest = 5'd0; m_in = 32'd0;
  endtask

  initial begin
    int guard;
    logic pv;
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rf_load", 32'(rf_load), 32'd0);
    chk("reset.ll_ready", 32'(ll_ready), 32'd1);
    check_all("reset");
    @(negedge clk); rst_n = 1'b1;

    // Pipeline only
    step("pipe_x5", 1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    chk("pipe_x5.dest_const", 32'(rf_dest), 32'd5);
    chk("pipe_x5.data_const", rf_in, 32'hDEADBEEF);
    step("pipe_x0", 1, 1, 5'd0, 32'h1111, 0, 5'd0, 32'd0);
    chk("pipe_x0.load_const", 32'(rf_load), 32'd0);
    step("pipe_nowen", 1, 0, 5'd6, 32'h2222, 0, 5'd0, 32'd0);

    // Idle drain
    step("drain_push", 0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h12);
    chk("drain.busy7", 32'(busy_mask[7]), 32'd1);
    idle("drain_1");
    chk("drain.write_const", {rf_load, 2'b0, rf_dest, rf_in[23:0]}, {1'b1, 2'b0, 5'd7, 24'h12});
    idle("drain_2");
    chk("drain.busy_clear", busy_mask, 32'd0);

    // Squash
    step("sq_push", 0, 0, 5'd0, 32'd0, 1, 5'd9, 32'hAA);
    step("sq_pipe", 1, 1, 5'd9, 32'hBB, 0, 5'd0, 32'd0);
    chk("sq.busy9", 32'(busy_mask[9]), 32'd0);
    chk("sq.data_const", rf_in, 32'hBB);
    idle("sq_dead");
    chk("sq.no_second_write", 32'(rf_load), 32'd0);
    idle("sq_idle");

    // Full FIFO and backpressure
    step("full_x1", 1, 1, 5'd20, 32'h100, 1, 5'd1, 32'h1);
    step("full_x2", 1, 1, 5'd21, 32'h101, 1, 5'd2, 32'h2);
    chk("full.ready_low", 32'(ll_ready), 32'd0);
    step("full_x3_held", 1, 1, 5'd22, 32'h102, 1, 5'd3, 32'h3);
    chk("full.x3_not_taken", 32'(m_last_push), 32'd0);
    guard = 0;
    do begin
      step("full_drain", 0, 0, 5'd0, 32'd0, 1, 5'd3, 32'h3);
      guard++;
    end while (!m_last_push && guard < 8);
    chk("full.x3_accepted_in_time", 32'(guard < 8), 32'd1);
    repeat (3) idle("full_tail");
    chk("full.ready_back", 32'(ll_ready), 32'd1);

    // Starvation
    step("st_push", 0, 0, 5'd0, 32'd0, 1, 5'd3, 32'h33);
    for (int k = 0; k < LIMIT; k++) step("st_hold", 1, 1, 5'd10, 32'(k), 0, 5'd0, 32'd0);
    chk("st.stall_set", 32'(pipe_stall), 32'd1);
    idle("st_release");
    chk("st.x3_written", {27'd0, rf_dest}, 32'd3);
    chk("st.stall_clear", 32'(pipe_stall), 32'd0);

    // Async reset with two entries queued and stall raised
    step("rs_push3", 0, 0, 5'd0, 32'd0, 1, 5'd3, 32'h3);
    step("rs_push4", 1, 1, 5'd11, 32'h44, 1, 5'd4, 32'h4);
    for (int k = 0; k < LIMIT; k++) step("rs_hold", 1, 1, 5'd12, 32'(k), 0, 5'd0, 32'd0);
    chk("rs.pre_stall", 32'(pipe_stall), 32'd1);
    #2 rst_n = 1'b0;
    pipe_valid = 1'b0; pipe_wen = 1'b0; ll_valid = 1'b0;
    #1;
    model_reset();
    chk("rs.async_load", 32'(rf_load), 32'd0);
    chk("rs.async_stall", 32'(pipe_stall), 32'd0);
    chk("rs.async_busy", busy_mask, 32'd0);
    check_all("rs.async");
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    repeat (4) idle("rs_after");

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      pv = ($urandom_range(0, 3) != 0);
      if (m_stall && ($urandom_range(0, 3) != 0)) pv = 1'b0;
      step("rand", pv, 1'($urandom_range(0, 4) != 0), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
